// File: rtl/riscv_pkg.sv
// Shared types and encodings for the multicycle RISC-V controller.
// Optional feature macro: MCC_JAL_EN (enables the JAL state and J-type immediate select).
package riscv_pkg;

    typedef enum logic [3:0] {
        S_FETCH    = 4'd0,
        S_DECODE   = 4'd1,
        S_MEMADR   = 4'd2,
        S_MEMREAD  = 4'd3,
        S_MEMWB    = 4'd4,
        S_MEMWRITE = 4'd5,
        S_EXECR    = 4'd6,
        S_EXECI    = 4'd7,
        S_ALUWB    = 4'd8,
        S_BEQ      = 4'd9,
        S_JAL      = 4'd10
    } state_t;

    localparam logic [6:0] OP_LW    = 7'b0000011;
    localparam logic [6:0] OP_SW    = 7'b0100011;
    localparam logic [6:0] OP_RTYPE = 7'b0110011;
    localparam logic [6:0] OP_ITYPE = 7'b0010011;
    localparam logic [6:0] OP_BEQ   = 7'b1100011;
    localparam logic [6:0] OP_JAL   = 7'b1101111;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    localparam logic [2:0] ALU_ADD = 3'b000;
    localparam logic [2:0] ALU_SUB = 3'b001;
    localparam logic [2:0] ALU_AND = 3'b010;
    localparam logic [2:0] ALU_OR  = 3'b011;
    localparam logic [2:0] ALU_SLT = 3'b101;
    localparam logic [2:0] ALU_UNK = 3'b111;

    localparam logic [1:0] SRCA_PC    = 2'b00;
    localparam logic [1:0] SRCA_OLDPC = 2'b01;
    localparam logic [1:0] SRCA_RS1   = 2'b10;

    localparam logic [1:0] SRCB_RS2  = 2'b00;
    localparam logic [1:0] SRCB_IMM  = 2'b01;
    localparam logic [1:0] SRCB_FOUR = 2'b10;

    localparam logic [1:0] RES_ALUOUT = 2'b00;
    localparam logic [1:0] RES_DATA   = 2'b01;
    localparam logic [1:0] RES_ALURES = 2'b10;

    localparam logic [1:0] IMM_I = 2'b00;
    localparam logic [1:0] IMM_S = 2'b01;
    localparam logic [1:0] IMM_B = 2'b10;
    localparam logic [1:0] IMM_J = 2'b11;

    function automatic logic [1:0] imm_src(input logic [6:0] op);
        case (op)
            OP_SW:   imm_src = IMM_S;
            OP_BEQ:  imm_src = IMM_B;
`ifdef MCC_JAL_EN
            OP_JAL:  imm_src = IMM_J;
`endif
            default: imm_src = IMM_I;
        endcase
    endfunction

endpackage

// File: rtl/alu_decoder.sv
// ALU operation decode from the FSM's ALUOp and the instruction funct fields.
module alu_decoder
    import riscv_pkg::*;
(
    input  logic [1:0] ALUOp,
    input  logic [2:0] funct3,
    input  logic       op_5,
    input  logic       funct7_5,
    output logic [2:0] ALUControl
);

    always_comb begin
        ALUControl = ALU_ADD;
        case (ALUOp)
            ALUOP_ADD: ALUControl = ALU_ADD;
            ALUOP_SUB: ALUControl = ALU_SUB;
            ALUOP_FUNCT: begin
                case (funct3)
                    // funct7_5 only selects sub for register-register ops; I-type has op_5=0
                    3'b000:  ALUControl = (op_5 && funct7_5) ? ALU_SUB : ALU_ADD;
                    3'b010:  ALUControl = ALU_SLT;
                    3'b110:  ALUControl = ALU_OR;
                    3'b111:  ALUControl = ALU_AND;
                    default: ALUControl = ALU_UNK;
                endcase
            end
            default: ALUControl = ALU_UNK;
        endcase
    end

endmodule

// File: rtl/multicycle_controller.sv
// Multicycle RISC-V control FSM: per-state datapath strobes/selects plus ALU decode.
// Optional feature macro: MCC_JAL_EN (JAL state and J-type decode).
module multicycle_controller
    import riscv_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    input  logic       zero,
    input  logic       mem_ready,
    output logic       PCWrite,
    output logic       AdrSrc,
    output logic       MemWrite,
    output logic       IRWrite,
    output logic       RegWrite,
    output logic [1:0] ResultSrc,
    output logic [1:0] ALUSrcA,
    output logic [1:0] ALUSrcB,
    output logic [1:0] ImmSrc,
    output logic [2:0] ALUControl,
    output logic       illegal_instr,
    output logic [3:0] state_o
);

    state_t     state_q, state_d;
    logic [1:0] alu_op;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_FETCH;
        else        state_q <= state_d;
    end

    always_comb begin
        state_d       = state_q;
        PCWrite       = 1'b0;
        AdrSrc        = 1'b0;
        MemWrite      = 1'b0;
        IRWrite       = 1'b0;
        RegWrite      = 1'b0;
        ResultSrc     = '0;
        ALUSrcA       = '0;
        ALUSrcB       = '0;
        alu_op        = ALUOP_ADD;
        illegal_instr = 1'b0;

        // Strobes are gated by rst_n so reset masks FETCH outputs combinationally
        if (rst_n) begin
            case (state_q)
                S_FETCH: begin
                    ALUSrcA   = SRCA_PC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALURES;
                    IRWrite   = mem_ready;
                    PCWrite   = mem_ready;
                    if (mem_ready) state_d = S_DECODE;
                end
                S_DECODE: begin
                    ALUSrcA = SRCA_OLDPC;
                    ALUSrcB = SRCB_IMM;
                    case (opcode)
                        OP_LW, OP_SW: state_d = S_MEMADR;
                        OP_RTYPE:     state_d = S_EXECR;
                        OP_ITYPE:     state_d = S_EXECI;
                        OP_BEQ:       state_d = S_BEQ;
`ifdef MCC_JAL_EN
                        OP_JAL:       state_d = S_JAL;
`endif
                        default: begin
                            state_d       = S_FETCH;
                            illegal_instr = 1'b1;
                        end
                    endcase
                end
                S_MEMADR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    state_d = (opcode == OP_SW) ? S_MEMWRITE : S_MEMREAD;
                end
                S_MEMREAD: begin
                    AdrSrc    = 1'b1;
                    ResultSrc = RES_ALUOUT;
                    if (mem_ready) state_d = S_MEMWB;
                end
                S_MEMWB: begin
                    ResultSrc = RES_DATA;
                    RegWrite  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_MEMWRITE: begin
                    AdrSrc   = 1'b1;
                    MemWrite = 1'b1;
                    if (mem_ready) state_d = S_FETCH;
                end
                S_EXECR: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_RS2;
                    alu_op  = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_EXECI: begin
                    ALUSrcA = SRCA_RS1;
                    ALUSrcB = SRCB_IMM;
                    alu_op  = ALUOP_FUNCT;
                    state_d = S_ALUWB;
                end
                S_ALUWB: begin
                    ResultSrc = RES_ALUOUT;
                    RegWrite  = 1'b1;
                    state_d   = S_FETCH;
                end
                S_BEQ: begin
                    ALUSrcA   = SRCA_RS1;
                    ALUSrcB   = SRCB_RS2;
                    alu_op    = ALUOP_SUB;
                    ResultSrc = RES_ALUOUT;
                    PCWrite   = zero;
                    state_d   = S_FETCH;
                end
`ifdef MCC_JAL_EN
                S_JAL: begin
                    ALUSrcA   = SRCA_OLDPC;
                    ALUSrcB   = SRCB_FOUR;
                    ResultSrc = RES_ALUOUT;
                    PCWrite   = 1'b1;
                    state_d   = S_ALUWB;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

    alu_decoder u_alu_decoder (
        .ALUOp      (alu_op),
        .funct3     (funct3),
        .op_5       (opcode[5]),
        .funct7_5   (funct7_5),
        .ALUControl (ALUControl)
    );

    assign ImmSrc  = rst_n ? imm_src(opcode) : '0;
    assign state_o = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Directed self-checking bench for multicycle_controller (honours MCC_JAL_EN if defined).
module tb_multicycle_controller;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       zero;
    logic       mem_ready;
    logic       PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite;
    logic [1:0] ResultSrc, ALUSrcA, ALUSrcB, ImmSrc;
    logic [2:0] ALUControl;
    logic       illegal_instr;
    logic [3:0] state_o;

    int unsigned n_cmp = 0;
    int unsigned n_err = 0;

    always #5 clk = ~clk;

    multicycle_controller dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .opcode        (opcode),
        .funct3        (funct3),
        .funct7_5      (funct7_5),
        .zero          (zero),
        .mem_ready     (mem_ready),
        .PCWrite       (PCWrite),
        .AdrSrc        (AdrSrc),
        .MemWrite      (MemWrite),
        .IRWrite       (IRWrite),
        .RegWrite      (RegWrite),
        .ResultSrc     (ResultSrc),
        .ALUSrcA       (ALUSrcA),
        .ALUSrcB       (ALUSrcB),
        .ImmSrc        (ImmSrc),
        .ALUControl    (ALUControl),
        .illegal_instr (illegal_instr),
        .state_o       (state_o)
    );

    task automatic check(input string tag, input logic [7:0] act, input logic [7:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic load(input logic [31:0] ins);
        opcode   = ins[6:0];
        funct3   = ins[14:12];
        funct7_5 = ins[30];
        #1;
    endtask

    // Execute one R-type op in EXECR, checking the decoded ALU operation
    task automatic rtype(input logic [2:0] f3, input logic f7, input logic [2:0] exp_alu, input string tag);
        opcode = 7'b0110011; funct3 = f3; funct7_5 = f7; #1;
        tick();
        tick();
        check({tag, "_state"}, 8'(state_o), 8'd6);
        check({tag, "_alu"}, 8'(ALUControl), 8'(exp_alu));
        tick();
        tick();
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        rst_n = 1'b0; mem_ready = 1'b1; zero = 1'b0;
        load(32'h002081B3);
        #12;
        check("rst_state",   8'(state_o),      8'd0);
        check("rst_pcwrite", 8'(PCWrite),      8'd0);
        check("rst_irwrite", 8'(IRWrite),      8'd0);
        check("rst_srcb",    8'(ALUSrcB),      8'd0);
        check("rst_res",     8'(ResultSrc),    8'd0);
        check("rst_alu",     8'(ALUControl),   8'd0);
        @(negedge clk);
        rst_n = 1'b1;
        #1;

        // add x3,x1,x2
        check("add_f_state", 8'(state_o),   8'd0);
        check("add_f_ir",    8'(IRWrite),   8'd1);
        check("add_f_pc",    8'(PCWrite),   8'd1);
        check("add_f_srcb",  8'(ALUSrcB),   8'd2);
        check("add_f_res",   8'(ResultSrc), 8'd2);
        check("add_f_rw",    8'(RegWrite),  8'd0);
        tick();
        check("add_d_state", 8'(state_o),   8'd1);
        check("add_d_srca",  8'(ALUSrcA),   8'd1);
        check("add_d_srcb",  8'(ALUSrcB),   8'd1);
        check("add_d_rw",    8'(RegWrite),  8'd0);
        tick();
        check("add_e_state", 8'(state_o),   8'd6);
        check("add_e_srca",  8'(ALUSrcA),   8'd2);
        check("add_e_srcb",  8'(ALUSrcB),   8'd0);
        check("add_e_alu",   8'(ALUControl), 8'd0);
        check("add_e_rw",    8'(RegWrite),  8'd0);
        tick();
        check("add_w_state", 8'(state_o),   8'd8);
        check("add_w_rw",    8'(RegWrite),  8'd1);
        check("add_w_res",   8'(ResultSrc), 8'd0);
        tick();
        check("add_back",    8'(state_o),   8'd0);

        rtype(3'b000, 1'b1, 3'b001, "sub");
        rtype(3'b111, 1'b0, 3'b010, "and");
        rtype(3'b110, 1'b0, 3'b011, "or");
        rtype(3'b010, 1'b0, 3'b101, "slt");
        rtype(3'b001, 1'b0, 3'b111, "unk");

        // addi with instruction bit 30 set must still add
        opcode = 7'b0010011; funct3 = 3'b000; funct7_5 = 1'b1; #1;
        check("addi_imm", 8'(ImmSrc), 8'd0);
        tick(); tick();
        check("addi_state", 8'(state_o),    8'd7);
        check("addi_srcb",  8'(ALUSrcB),    8'd1);
        check("addi_alu",   8'(ALUControl), 8'd0);
        tick(); tick();

        // FETCH waits for memory
        mem_ready = 1'b0; #1;
        check("fwait_ir", 8'(IRWrite), 8'd0);
        check("fwait_pc", 8'(PCWrite), 8'd0);
        tick();
        check("fwait_state", 8'(state_o), 8'd0);
        mem_ready = 1'b1; #1;

        // lw with three stall cycles
        load(32'h0000A183);
        tick(); tick();
        check("lw_adr_state", 8'(state_o),    8'd2);
        check("lw_adr_srca",  8'(ALUSrcA),    8'd2);
        check("lw_adr_alu",   8'(ALUControl), 8'd0);
        tick();
        for (int i = 0; i < 3; i++) begin
            mem_ready = 1'b0; #1;
            check("lw_rd_state", 8'(state_o), 8'd3);
            check("lw_rd_adr",   8'(AdrSrc),  8'd1);
            tick();
        end
        mem_ready = 1'b1; #1;
        check("lw_rd_last", 8'(state_o), 8'd3);
        tick();
        check("lw_wb_state", 8'(state_o),   8'd4);
        check("lw_wb_res",   8'(ResultSrc), 8'd1);
        check("lw_wb_rw",    8'(RegWrite),  8'd1);
        tick();
        check("lw_back", 8'(state_o), 8'd0);

        // beq taken and not taken
        for (int t = 0; t < 2; t++) begin
            opcode = 7'b1100011; funct3 = 3'b000; funct7_5 = 1'b0; zero = (t == 0); #1;
            tick();
            check("beq_imm", 8'(ImmSrc), 8'd2);
            tick();
            check("beq_state", 8'(state_o),    8'd9);
            check("beq_alu",   8'(ALUControl), 8'd1);
            check("beq_pc",    8'(PCWrite),    (t == 0) ? 8'd1 : 8'd0);
            tick();
            check("beq_back", 8'(state_o), 8'd0);
        end
        zero = 1'b0;

        // unsupported opcode
        opcode = 7'h7F; #1;
        tick();
        check("ill_pulse", 8'(illegal_instr), 8'd1);
        check("ill_rw",    8'(RegWrite),      8'd0);
        check("ill_mw",    8'(MemWrite),      8'd0);
        tick();
        check("ill_state", 8'(state_o),       8'd0);
        check("ill_clear", 8'(illegal_instr), 8'd0);

        // jal
        load(32'h008000EF);
        tick();
`ifdef MCC_JAL_EN
        check("jal_imm", 8'(ImmSrc),        8'd3);
        check("jal_ill", 8'(illegal_instr), 8'd0);
        tick();
        check("jal_state", 8'(state_o), 8'd10);
        check("jal_pc",    8'(PCWrite), 8'd1);
        check("jal_srcb",  8'(ALUSrcB), 8'd2);
        tick();
        check("jal_wb", 8'(state_o), 8'd8);
        tick();
`else
        check("jal_imm", 8'(ImmSrc),        8'd0);
        check("jal_ill", 8'(illegal_instr), 8'd1);
        tick();
        check("jal_back", 8'(state_o), 8'd0);
`endif

        // sw interrupted by reset in the second stall cycle
        opcode = 7'b0100011; funct3 = 3'b010; funct7_5 = 1'b0; #1;
        tick();
        check("sw_imm", 8'(ImmSrc), 8'd1);
        tick(); tick();
        mem_ready = 1'b0; #1;
        check("sw_state", 8'(state_o),  8'd5);
        check("sw_mw1",   8'(MemWrite), 8'd1);
        tick();
        check("sw_mw2",   8'(MemWrite), 8'd1);
        check("sw_adr",   8'(AdrSrc),   8'd1);
        rst_n = 1'b0; #1;
        check("swrst_mw",    8'(MemWrite), 8'd0);
        check("swrst_state", 8'(state_o),  8'd0);
        #2;
        rst_n = 1'b1;
        tick();
        check("swrel_ir",    8'(IRWrite),  8'd0);
        check("swrel_state", 8'(state_o),  8'd0);
        tick();
        check("swrel_mw",    8'(MemWrite), 8'd0);
        mem_ready = 1'b1; #1;
        check("swrel_fetch", 8'(IRWrite), 8'd1);
        tick();
        check("swrel_dec", 8'(state_o), 8'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/multicycle_controller.md
MULTICYCLE_CONTROLLER -- requirements
Module: multicycle_controller

Interface
REQ-001 Parameters: none.
REQ-002 clk  in  1  rising-edge clock.
REQ-003 rst_n  in  1  reset, asynchronous and active-low.
REQ-004 opcode  in  7  instruction[6:0], taken from the instruction register.
REQ-005 funct3  in  3  instruction[14:12].
REQ-006 funct7_5  in  1  instruction[30].
REQ-007 zero  in  1  ALU zero flag.
REQ-008 mem_ready  in  1  memory access complete this cycle.
REQ-009 PCWrite, AdrSrc, MemWrite, IRWrite, RegWrite  out  1 each  datapath strobes and selects.
REQ-010 ResultSrc, ALUSrcA, ALUSrcB, ImmSrc  out  2 each  mux selects.
REQ-011 ALUControl  out  3  ALU operation.
REQ-012 illegal_instr  out  1  one-cycle pulse on an unsupported opcode.
REQ-013 state_o  out  4  current state encoding, for debug.

Function
REQ-014 States: FETCH, DECODE, MEMADR, MEMREAD, MEMWB, MEMWRITE, EXECR, EXECI, ALUWB, BEQ, JAL.
REQ-015 FETCH: AdrSrc=0, ALUSrcA=00, ALUSrcB=10, ResultSrc=10.
  - IRWrite=1 and PCWrite=1 only when mem_ready=1; otherwise the FSM stays in FETCH.
  - mem_ready=1 -> DECODE.
REQ-016 DECODE: ALUSrcA=01, ALUSrcB=01, ALU add.
  - 0000011 or 0100011 -> MEMADR.
  - 0110011 -> EXECR.
  - 0010011 -> EXECI.
  - 1100011 -> BEQ.
  - 1101111 -> JAL.
  - any other opcode -> FETCH with illegal_instr=1.
REQ-017 MEMADR: ALUSrcA=10, ALUSrcB=01, ALU add; lw -> MEMREAD, sw -> MEMWRITE.
REQ-018 MEMREAD: AdrSrc=1, ResultSrc=00; holds until mem_ready=1, then -> MEMWB.
REQ-019 MEMWB: ResultSrc=01, RegWrite=1; -> FETCH.
REQ-020 MEMWRITE: AdrSrc=1, MemWrite=1 held until mem_ready=1, then -> FETCH; a write is never aborted mid-access except by reset.
REQ-021 EXECR: ALUSrcA=10, ALUSrcB=00. EXECI: ALUSrcA=10, ALUSrcB=01. Both -> ALUWB.
REQ-022 ALUWB: ResultSrc=00, RegWrite=1; -> FETCH.
REQ-023 BEQ: ALUSrcA=10, ALUSrcB=00, ALU sub, ResultSrc=00; PCWrite=zero; -> FETCH.
REQ-024 JAL: ALUSrcA=01, ALUSrcB=10, ResultSrc=00, PCWrite=1; -> ALUWB.
REQ-025 Any output not listed for a state is 0 in that state.
REQ-026 ImmSrc is combinational from opcode: I=00, S=01, B=10, J=11, others=00.
REQ-027 ALUControl comes from the ALU decode table:
  - add=000, sub=001, and=010, or=011, slt=101, unknown=111.
  - sub is selected when opcode[5]=1 and funct7_5=1; for I-type, funct7_5 is ignored.
REQ-028 Every strobe is combinational from the current state and inputs; state changes only on clk.

Reset
REQ-029 While rst_n=0, outputs are:
  - state=FETCH;
  - PCWrite, IRWrite, MemWrite, RegWrite, illegal_instr = 0, overriding the FETCH strobes;
  - all selects = 00, ALUControl=000.
REQ-030 Reset asserted in any state, including mid-MEMWRITE, returns to FETCH immediately.
REQ-031 After release, the first fetch strobe is on the first edge with mem_ready=1.

Configuration
REQ-032 Macro MCC_JAL_EN.
  - Defined: the JAL state exists and 1101111 decodes to JAL.
  - Undefined: 1101111 is illegal (REQ-016 default path) and ImmSrc=11 is never driven.

Structure
REQ-033 Package riscv_pkg holds:
  - the state enum;
  - opcode constants (LW, SW, RTYPE, ITYPE, BEQ, JAL);
  - ALUControl encodings;
  - ALUSrcA/ALUSrcB/ResultSrc select constants.
REQ-034 Sub-module alu_decoder (ALUOp, funct3, opcode[5], funct7_5 -> ALUControl) is instantiated once; the FSM drives ALUOp (00 add, 01 sub, 10 funct decode).

Verification
REQ-035 add x3,x1,x2 (0x002081B3), mem_ready=1 throughout:
  - states FETCH, DECODE, EXECR, ALUWB;
  - RegWrite=1 only in cycle 4, ALUControl=000 in EXECR.
REQ-036 lw (0x0000A183), mem_ready low 3 cycles in MEMREAD:
  - 3 extra MEMREAD cycles, then MEMWB with ResultSrc=01, RegWrite=1.
REQ-037 beq, both branch outcomes:
  - zero=1: PCWrite=1 in BEQ;
  - zero=0: PCWrite=0;
  - in both cases the next state is FETCH.
REQ-038 Opcode 0x7F at DECODE -> illegal_instr pulses 1 cycle, next state FETCH, no RegWrite or MemWrite.
REQ-039 rst_n dropped during the second MEMWRITE stall cycle:
  - MemWrite=0 asynchronously, state_o=FETCH;
  - no further strobes until mem_ready=1.
REQ-040 MCC_JAL_EN defined vs undefined, jal x1,8 (0x008000EF):
  - defined: JAL then ALUWB;
  - undefined: illegal_instr=1.
